// File: rtl/spi_rx_pkg.sv
// rtl/spi_rx_pkg.sv - shared state encodings and bit-order constants for the SPI link
package spi_rx_pkg;

    localparam logic [0:0] SPI_IDLE  = 1'b0;
    localparam logic [0:0] SPI_SHIFT = 1'b1;

    localparam bit MSB_FIRST = 1'b1;
    localparam bit LSB_FIRST = 1'b0;

endpackage

// File: rtl/spi_rx.sv
// rtl/spi_rx.sv - SPI receive deserialiser with start/busy/done handshake and valid/ack output
module spi_rx
    import spi_rx_pkg::*;
#(
    parameter int BitCount     = 5,
    parameter int BitCountLog2 = 3,
    parameter bit MsbFirst     = MSB_FIRST
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                miso,
    input  logic                start,
    output logic [BitCount-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                valid,
    input  logic                data_ack,
    output logic                overrun
);

    localparam logic [BitCountLog2-1:0] LastIdx = BitCountLog2'(BitCount - 1);

    logic [0:0]              state;
    logic [BitCountLog2-1:0] cnt;
    logic [BitCount-1:0]     shreg;
    logic [BitCount-1:0]     shreg_next;
    logic                    last_bit;

    // The assembled word includes the bit being sampled on this edge.
    always_comb begin
        shreg_next = shreg;
        if (MsbFirst == MSB_FIRST) begin
            shreg_next = {shreg[BitCount-2:0], miso};
        end else begin
            shreg_next = {miso, shreg[BitCount-1:1]};
        end
    end

    assign last_bit = (state == SPI_SHIFT) && (cnt == LastIdx);
    assign busy     = (state == SPI_SHIFT);

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state   <= SPI_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            data    <= '0;
            done    <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (data_ack) begin
                valid <= 1'b0;
            end
            case (state)
                SPI_IDLE: begin
                    if (start) begin
                        state <= SPI_SHIFT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    shreg <= shreg_next;
                    cnt   <= cnt + BitCountLog2'(1);
                    if (last_bit) begin
                        // Completion takes priority over a same-edge acknowledge.
                        data  <= shreg_next;
                        done  <= 1'b1;
                        valid <= 1'b1;
                        if (valid && !data_ack) begin
                            overrun <= 1'b1;
                        end
                        if (start) begin
                            cnt <= '0;
                        end else begin
                            state <= SPI_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// tb/tb_spi_rx.sv - directed-vector bench for spi_rx, MSB-first and LSB-first instances
module tb_spi_rx;

    logic       sclk = 1'b0;
    logic       reset;
    logic       miso;
    logic       start;
    logic       data_ack;
    logic [4:0] data;
    logic       busy, done, valid, overrun;
    logic [4:0] data_l;
    logic       busy_l, done_l, valid_l, overrun_l;

    int vectors    = 0;
    int miscompares = 0;

    spi_rx #(.BitCount(5), .BitCountLog2(3), .MsbFirst(1'b1)) u_msb (
        .sclk(sclk), .reset(reset), .miso(miso), .start(start),
        .data(data), .busy(busy), .done(done), .valid(valid),
        .data_ack(data_ack), .overrun(overrun)
    );

    spi_rx #(.BitCount(5), .BitCountLog2(3), .MsbFirst(1'b0)) u_lsb (
        .sclk(sclk), .reset(reset), .miso(miso), .start(start),
        .data(data_l), .busy(busy_l), .done(done_l), .valid(valid_l),
        .data_ack(data_ack), .overrun(overrun_l)
    );

    always #5 sclk = ~sclk;

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic kick;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tick i drives seq[4-i], start_mask[i], ack_mask[i] and records done/busy after that edge.
    task automatic shift_bits(input logic [4:0] seq, input logic [4:0] start_mask,
                              input logic [4:0] ack_mask,
                              output logic [4:0] done_mask, output logic [4:0] busy_mask);
        for (int i = 0; i < 5; i++) begin
            miso     = seq[4-i];
            start    = start_mask[i];
            data_ack = ack_mask[i];
            tick();
            done_mask[i] = done;
            busy_mask[i] = busy;
        end
        miso     = 1'b0;
        start    = 1'b0;
        data_ack = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if ({data, busy, done, valid, overrun} !== 9'h0) begin
            miscompares++;
            $display("FAIL reset_msb: got data=%h busy=%b done=%b valid=%b overrun=%b expected all 0",
                     data, busy, done, valid, overrun);
        end
        vectors++;
        if ({data_l, busy_l, done_l, valid_l, overrun_l} !== 9'h0) begin
            miscompares++;
            $display("FAIL reset_lsb: got data=%h busy=%b done=%b valid=%b overrun=%b expected all 0",
                     data_l, busy_l, done_l, valid_l, overrun_l);
        end
    endtask

    task automatic test_single_frame;
        logic [4:0] dm, bm;
        kick();
        shift_bits(5'b01100, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h0C) begin
            miscompares++;
            $display("FAIL t1_data: got %h expected 0c", data);
        end
        vectors++;
        if (dm !== 5'b10000) begin
            miscompares++;
            $display("FAIL t1_done_timing: got %b expected 10000", dm);
        end
        vectors++;
        if (bm !== 5'b01111) begin
            miscompares++;
            $display("FAIL t1_busy: got %b expected 01111", bm);
        end
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_valid: got %b expected 1", valid);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL t1_after: got done=%b busy=%b expected 0 0", done, busy);
        end
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_ack: got valid=%b expected 0", valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0] dm, bm;
        kick();
        shift_bits(5'h15, 5'b10000, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h15 || dm !== 5'b10000 || bm !== 5'b11111) begin
            miscompares++;
            $display("FAIL t2_first: got data=%h done=%b busy=%b expected 15 10000 11111", data, dm, bm);
        end
        shift_bits(5'h0A, 5'b00000, 5'b00001, dm, bm);
        vectors++;
        if (data !== 5'h0A || dm !== 5'b10000 || bm !== 5'b01111) begin
            miscompares++;
            $display("FAIL t2_second: got data=%h done=%b busy=%b expected 0a 10000 01111", data, dm, bm);
        end
        vectors++;
        if (overrun !== 1'b0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_flags: got overrun=%b valid=%b expected 0 1", overrun, valid);
        end
    endtask

    task automatic test_ack_collision;
        logic [4:0] dm, bm;
        kick();
        shift_bits(5'h07, 5'b00000, 5'b10000, dm, bm);
        vectors++;
        if (data !== 5'h07 || valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_collision: got data=%h valid=%b overrun=%b expected 07 1 0",
                     data, valid, overrun);
        end
    endtask

    task automatic test_overrun;
        logic [4:0] dm, bm;
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        kick();
        shift_bits(5'h0C, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h0C || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_first: got data=%h overrun=%b expected 0c 0", data, overrun);
        end
        kick();
        shift_bits(5'h1F, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h1F || overrun !== 1'b1 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_overrun: got data=%h overrun=%b valid=%b expected 1f 1 1",
                     data, overrun, valid);
        end
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        tick();
        vectors++;
        if (valid !== 1'b0 || overrun !== 1'b1 || data !== 5'h1F) begin
            miscompares++;
            $display("FAIL t3_ack: got valid=%b overrun=%b data=%h expected 0 1 1f",
                     valid, overrun, data);
        end
    endtask

    task automatic test_reset_midframe;
        logic [4:0] dm, bm;
        logic       seen_done;
        kick();
        for (int i = 0; i < 3; i++) begin
            miso = 1'b1;
            tick();
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || data !== 5'h00 || overrun !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_async: got busy=%b data=%h overrun=%b valid=%b expected 0 00 0 0",
                     busy, data, overrun, valid);
        end
        #1;
        reset = 1'b0;
        miso  = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_done = seen_done | done | busy;
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_no_done: got done_or_busy=%b expected 0", seen_done);
        end
        kick();
        shift_bits(5'h13, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h13 || dm !== 5'b10000) begin
            miscompares++;
            $display("FAIL t4_next: got data=%h done=%b expected 13 10000", data, dm);
        end
    endtask

    task automatic test_lsb_first;
        logic [4:0] dm, bm;
        kick();
        shift_bits(5'b10101, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data_l !== 5'h15) begin
            miscompares++;
            $display("FAIL t5_first: got %h expected 15", data_l);
        end
        kick();
        shift_bits(5'b00110, 5'b00000, 5'b00000, dm, bm);
        vectors++;
        if (data_l !== 5'h0C) begin
            miscompares++;
            $display("FAIL t5_second: got %h expected 0c", data_l);
        end
        vectors++;
        if (data !== 5'h06) begin
            miscompares++;
            $display("FAIL t5_msb_ref: got %h expected 06", data);
        end
    endtask

    task automatic test_start_while_busy;
        logic [4:0] dm, bm;
        kick();
        shift_bits(5'h1A, 5'b00100, 5'b00000, dm, bm);
        vectors++;
        if (data !== 5'h1A || dm !== 5'b10000 || bm !== 5'b01111) begin
            miscompares++;
            $display("FAIL t6_ignore: got data=%h done=%b busy=%b expected 1a 10000 01111", data, dm, bm);
        end
        tick();
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL t6_after: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        miso     = 1'b0;
        start    = 1'b0;
        data_ack = 1'b0;
        #2;
        test_reset();
        #8;
        reset = 1'b0;
        test_single_frame();
        test_back_to_back();
        test_ack_collision();
        test_overrun();
        test_reset_midframe();
        test_lsb_first();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
